// File: rtl/matrix_pkg.sv
// Shared constants, types and helpers for the matrix storage controller.
package matrix_pkg;
   localparam int DATA_W    = 200;
   localparam int DIM_MAX   = 5;
   localparam int MAX_SLOTS = 8;
   localparam int NUM_CLS   = DIM_MAX * DIM_MAX;
   localparam int CLS_W     = 5;
   localparam int SLOT_W    = $clog2(MAX_SLOTS);
   localparam int ADDR_W    = CLS_W + SLOT_W;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOOKUP,
      S_WRITE
   } state_e;

   typedef enum logic [2:0] {
      ERR_NONE = 3'b000,
      ERR_DIM  = 3'b001,
      ERR_OVF  = 3'b010
   } err_e;

   typedef struct packed {
      logic [3:0]        m;
      logic [3:0]        n;
      logic [DATA_W-1:0] data;
   } entry_t;

   function automatic logic dim_ok(input logic [3:0] m,
                                   input logic [3:0] n);
      return (m != 4'd0) && (m <= 4'(DIM_MAX)) &&
             (n != 4'd0) && (n <= 4'(DIM_MAX));
   endfunction

   function automatic logic [CLS_W-1:0] class_idx(input logic [3:0] m,
                                                  input logic [3:0] n);
      logic [CLS_W-1:0] mi;
      logic [CLS_W-1:0] ni;
      mi = CLS_W'(m) - CLS_W'(1);
      ni = CLS_W'(n) - CLS_W'(1);
      return mi * CLS_W'(DIM_MAX) + ni;
   endfunction
endpackage

// File: rtl/matrix_slot_table.sv
// Per-class stored count and ring write pointer, with sync clear.
module matrix_slot_table
   import matrix_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic [CLS_W-1:0]  rd_cls_i,
   output logic [CNT_W-1:0]  rd_cnt_o,
   output logic [SLOT_W-1:0] rd_wptr_o,
   input  logic [CLS_W-1:0]  q_cls_i,
   output logic [CNT_W-1:0]  q_cnt_o,
   input  logic              we_i,
   input  logic [CLS_W-1:0]  wr_cls_i,
   input  logic [CNT_W-1:0]  wr_cnt_i,
   input  logic [SLOT_W-1:0] wr_wptr_i
);
   logic [CNT_W-1:0]  cnt_q  [NUM_CLS];
   logic [SLOT_W-1:0] wptr_q [NUM_CLS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CLS; i++) begin
            cnt_q[i]  <= '0;
            wptr_q[i] <= '0;
         end
      end else if (clr_i) begin
         for (int i = 0; i < NUM_CLS; i++) begin
            cnt_q[i]  <= '0;
            wptr_q[i] <= '0;
         end
      end else if (we_i && (wr_cls_i < CLS_W'(NUM_CLS))) begin
         cnt_q[wr_cls_i]  <= wr_cnt_i;
         wptr_q[wr_cls_i] <= wr_wptr_i;
      end
   end

   assign rd_cnt_o  = (rd_cls_i < CLS_W'(NUM_CLS)) ? cnt_q[rd_cls_i] : '0;
   assign rd_wptr_o = (rd_cls_i < CLS_W'(NUM_CLS)) ? wptr_q[rd_cls_i] : '0;
   assign q_cnt_o   = (q_cls_i < CLS_W'(NUM_CLS)) ? cnt_q[q_cls_i] : '0;
endmodule

// File: rtl/matrix_store_ctrl.sv
// Arbitrates manual/generator stores into per-class ring slots of the matrix RAM.
module matrix_store_ctrl
   import matrix_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_store_en,
   input  logic [3:0]        in_m,
   input  logic [3:0]        in_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              gen_store_en,
   input  logic [3:0]        gen_m,
   input  logic [3:0]        gen_n,
   input  logic [DATA_W-1:0] gen_data,
   input  logic [3:0]        max_mat_num,
   input  logic              clr,
   input  logic [3:0]        query_m,
   input  logic [3:0]        query_n,
   output logic [3:0]        query_cnt,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [3:0]        wr_m,
   output logic [3:0]        wr_n,
   output logic              in_ack,
   output logic              gen_ack,
   output logic              busy,
   output logic              err_ovf,
   output logic              err_dim
);
   state_e state_q;
   entry_t in_buf_q, gen_buf_q, work_q;
   logic in_vld_q, gen_vld_q, rr_gen_q, src_gen_q;
   logic wr_en_q, in_ack_q, gen_ack_q, err_ovf_q, err_dim_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [3:0] wr_m_q, wr_n_q, query_cnt_q;

   logic grant_in, grant_gen, in_drop, gen_drop, tbl_we;
   logic [CLS_W-1:0] cls, q_cls;
   logic [CNT_W-1:0] rd_cnt, q_cnt, cap, new_cnt, slot_inc;
   logic [SLOT_W-1:0] rd_wptr, slot, new_wptr;
   err_e lk_err;

   // Both buffers valid: serve whoever was not served last.
   assign grant_in  = (state_q == S_IDLE) && in_vld_q &&
                      (!gen_vld_q || rr_gen_q);
   assign grant_gen = (state_q == S_IDLE) && gen_vld_q && !grant_in;
   assign in_drop   = in_store_en && in_vld_q && !grant_in;
   assign gen_drop  = gen_store_en && gen_vld_q && !grant_gen;

   assign cls   = class_idx(work_q.m, work_q.n);
   assign q_cls = dim_ok(query_m, query_n) ?
                  class_idx(query_m, query_n) : '0;

   always_comb begin
      cap = max_mat_num;
      if (max_mat_num == 4'd0)
         cap = 4'd1;
      else if (max_mat_num > 4'(MAX_SLOTS))
         cap = 4'(MAX_SLOTS);
      slot     = ({1'b0, rd_wptr} >= cap) ? '0 : rd_wptr;
      slot_inc = {1'b0, slot} + 4'd1;
      new_wptr = (slot_inc == cap) ? '0 : slot_inc[SLOT_W-1:0];
      new_cnt  = (rd_cnt >= cap) ? cap : rd_cnt + 4'd1;
      lk_err   = dim_ok(work_q.m, work_q.n) ? ERR_NONE : ERR_DIM;
   end

   assign tbl_we = (state_q == S_LOOKUP) && (lk_err == ERR_NONE);

   matrix_slot_table u_tbl (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (clr),
      .rd_cls_i  (cls),
      .rd_cnt_o  (rd_cnt),
      .rd_wptr_o (rd_wptr),
      .q_cls_i   (q_cls),
      .q_cnt_o   (q_cnt),
      .we_i      (tbl_we),
      .wr_cls_i  (cls),
      .wr_cnt_i  (new_cnt),
      .wr_wptr_i (new_wptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_buf_q    <= '0;
         gen_buf_q   <= '0;
         work_q      <= '0;
         in_vld_q    <= 1'b0;
         gen_vld_q   <= 1'b0;
         rr_gen_q    <= 1'b1;
         src_gen_q   <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_m_q      <= '0;
         wr_n_q      <= '0;
         in_ack_q    <= 1'b0;
         gen_ack_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_dim_q   <= 1'b0;
         query_cnt_q <= '0;
      end else begin
         wr_en_q     <= 1'b0;
         in_ack_q    <= 1'b0;
         gen_ack_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_dim_q   <= 1'b0;
         query_cnt_q <= dim_ok(query_m, query_n) ? q_cnt : '0;
         if (clr) begin
            in_vld_q  <= 1'b0;
            gen_vld_q <= 1'b0;
            state_q   <= S_IDLE;
         end else begin
            err_ovf_q <= in_drop || gen_drop;
            if (in_store_en && !in_drop) begin
               in_buf_q <= '{m: in_m, n: in_n, data: in_data};
               in_vld_q <= 1'b1;
            end else if (grant_in) begin
               in_vld_q <= 1'b0;
            end
            if (gen_store_en && !gen_drop) begin
               gen_buf_q <= '{m: gen_m, n: gen_n, data: gen_data};
               gen_vld_q <= 1'b1;
            end else if (grant_gen) begin
               gen_vld_q <= 1'b0;
            end
            unique case (state_q)
               S_IDLE: begin
                  if (grant_in || grant_gen) begin
                     work_q    <= grant_gen ? gen_buf_q : in_buf_q;
                     src_gen_q <= grant_gen;
                     rr_gen_q  <= grant_gen;
                     state_q   <= S_LOOKUP;
                  end
               end
               S_LOOKUP: begin
                  if (lk_err == ERR_NONE) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= {cls, slot};
                     wr_data_q <= work_q.data;
                     wr_m_q    <= work_q.m;
                     wr_n_q    <= work_q.n;
                     in_ack_q  <= !src_gen_q;
                     gen_ack_q <= src_gen_q;
                     state_q   <= S_WRITE;
                  end else begin
                     err_dim_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end
               end
               S_WRITE: state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy      = (state_q != S_IDLE) || in_vld_q || gen_vld_q;
   assign query_cnt = query_cnt_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign wr_m      = wr_m_q;
   assign wr_n      = wr_n_q;
   assign in_ack    = in_ack_q;
   assign gen_ack   = gen_ack_q;
   assign err_ovf   = err_ovf_q;
   assign err_dim   = err_dim_q;
endmodule

// File: tb/tb_matrix_store_ctrl.sv
// Self-checking bench for matrix_store_ctrl: vector table plus corner sequences.
module tb_matrix_store_ctrl;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_store_en, gen_store_en, clr;
   logic [3:0]   in_m, in_n, gen_m, gen_n, max_mat_num;
   logic [3:0]   query_m, query_n, query_cnt;
   logic [199:0] in_data, gen_data, wr_data;
   logic         wr_en, in_ack, gen_ack, busy, err_ovf, err_dim;
   logic [7:0]   wr_addr;
   logic [3:0]   wr_m, wr_n;

   always #5 clk = ~clk;

   matrix_store_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .in_store_en(in_store_en), .in_m(in_m), .in_n(in_n),
      .in_data(in_data),
      .gen_store_en(gen_store_en), .gen_m(gen_m), .gen_n(gen_n),
      .gen_data(gen_data),
      .max_mat_num(max_mat_num), .clr(clr),
      .query_m(query_m), .query_n(query_n), .query_cnt(query_cnt),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_m(wr_m), .wr_n(wr_n),
      .in_ack(in_ack), .gen_ack(gen_ack), .busy(busy),
      .err_ovf(err_ovf), .err_dim(err_dim)
   );

   typedef struct {
      logic [7:0]   addr;
      logic [199:0] data;
      logic [3:0]   m;
      logic [3:0]   n;
      bit           gen;
   } wr_t;

   typedef struct {
      bit         gen;
      logic [3:0] m;
      logic [3:0] n;
      logic [3:0] mx;
      logic [7:0] addr;
      logic [3:0] cnt;
      bit         derr;
   } vec_t;

   wr_t  sb[$];
   vec_t vt[15];
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_wr = 0;

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got %0h want %0h", name, act, exp);
   endtask

   function automatic logic [199:0] rand_data();
      logic [223:0] r;
      for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
      return r[199:0];
   endfunction

   task automatic expect_wr(input logic [7:0] a, input logic [199:0] d,
                            input logic [3:0] m, input logic [3:0] n,
                            input bit g);
      wr_t e;
      e.addr = a; e.data = d; e.m = m; e.n = n; e.gen = g;
      sb.push_back(e);
   endtask

   task automatic store(input bit g, input logic [3:0] m,
                        input logic [3:0] n, input logic [199:0] d);
      if (g) begin
         gen_store_en = 1'b1; gen_m = m; gen_n = n; gen_data = d;
      end else begin
         in_store_en = 1'b1; in_m = m; in_n = n; in_data = d;
      end
   endtask

   task automatic idle_in();
      in_store_en = 1'b0;
      gen_store_en = 1'b0;
      clr = 1'b0;
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (wr_en === 1'b1) begin
         n_wr++;
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_wr got addr %0h want no write", wr_addr);
         end else begin
            e = sb.pop_front();
            chk("sb_addr", wr_addr, e.addr);
            chk("sb_data", wr_data, e.data);
            chk("sb_m", wr_m, e.m);
            chk("sb_n", wr_n, e.n);
            chk("sb_in_ack", in_ack, !e.gen);
            chk("sb_gen_ack", gen_ack, e.gen);
         end
      end
   end

   task automatic run_vec(input vec_t v, input int i);
      logic [199:0] d;
      d = rand_data();
      max_mat_num = v.mx;
      if (!v.derr) expect_wr(v.addr, d, v.m, v.n, v.gen);
      store(v.gen, v.m, v.n, d);
      @(negedge clk);
      idle_in();
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_wr_en", i), wr_en, !v.derr);
      chk($sformatf("vec%0d_err_dim", i), err_dim, v.derr);
      query_m = v.m;
      query_n = v.n;
      @(negedge clk);
      chk($sformatf("vec%0d_cnt", i), query_cnt, v.cnt);
   endtask

   initial begin
      logic [199:0] d0, d1;
      int w0;
      idle_in();
      in_m = 0; in_n = 0; gen_m = 0; gen_n = 0;
      in_data = '0; gen_data = '0;
      max_mat_num = 4'd8; query_m = 0; query_n = 0;

      vt[0]  = '{1'b1, 4'd2, 4'd3, 4'd4,  8'd56,  4'd1, 1'b0};
      vt[1]  = '{1'b1, 4'd2, 4'd3, 4'd4,  8'd57,  4'd2, 1'b0};
      vt[2]  = '{1'b0, 4'd3, 4'd3, 4'd3,  8'd96,  4'd1, 1'b0};
      vt[3]  = '{1'b0, 4'd3, 4'd3, 4'd3,  8'd97,  4'd2, 1'b0};
      vt[4]  = '{1'b1, 4'd3, 4'd3, 4'd3,  8'd98,  4'd3, 1'b0};
      vt[5]  = '{1'b0, 4'd3, 4'd3, 4'd3,  8'd96,  4'd3, 1'b0};
      vt[6]  = '{1'b1, 4'd3, 4'd3, 4'd3,  8'd97,  4'd3, 1'b0};
      vt[7]  = '{1'b0, 4'd1, 4'd1, 4'd0,  8'd0,   4'd1, 1'b0};
      vt[8]  = '{1'b0, 4'd1, 4'd1, 4'd0,  8'd0,   4'd1, 1'b0};
      vt[9]  = '{1'b1, 4'd5, 4'd5, 4'd15, 8'd192, 4'd1, 1'b0};
      vt[10] = '{1'b0, 4'd6, 4'd2, 4'd4,  8'd0,   4'd0, 1'b1};
      vt[11] = '{1'b1, 4'd2, 4'd0, 4'd4,  8'd0,   4'd0, 1'b1};
      vt[12] = '{1'b1, 4'd2, 4'd3, 4'd1,  8'd56,  4'd1, 1'b0};
      vt[13] = '{1'b1, 4'd2, 4'd3, 4'd4,  8'd56,  4'd2, 1'b0};
      vt[14] = '{1'b0, 4'd4, 4'd5, 4'd8,  8'd152, 4'd1, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_in_ack", in_ack, 0);
      chk("rst_gen_ack", gen_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_ovf", err_ovf, 0);
      chk("rst_err_dim", err_dim, 0);
      chk("rst_query_cnt", query_cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Simultaneous pulses: manual first after reset.
      d0 = rand_data(); d1 = rand_data();
      expect_wr(8'd0, d0, 4'd1, 4'd1, 1'b0);
      expect_wr(8'd192, d1, 4'd5, 4'd5, 1'b1);
      store(1'b0, 4'd1, 4'd1, d0);
      store(1'b1, 4'd5, 4'd5, d1);
      @(negedge clk);
      idle_in();
      chk("both_busy", busy, 1);
      @(negedge clk);
      @(negedge clk);
      chk("both_wr1", wr_en, 1);
      @(negedge clk);
      chk("both_gap1", wr_en, 0);
      @(negedge clk);
      chk("both_gap2", wr_en, 0);
      @(negedge clk);
      chk("both_wr2", wr_en, 1);
      chk("both_no_ovf", err_ovf, 0);
      @(negedge clk);

      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      query_m = 1; query_n = 1;
      @(negedge clk);
      chk("clr_q11", query_cnt, 0);
      query_m = 5; query_n = 5;
      @(negedge clk);
      chk("clr_q55", query_cnt, 0);

      for (int i = 0; i < 15; i++) run_vec(vt[i], i);

      // Overflow: gen buffer held while FSM serves manual entry.
      max_mat_num = 4'd8;
      w0 = n_wr;
      d0 = rand_data(); d1 = rand_data();
      expect_wr(8'd48, d0, 4'd2, 4'd2, 1'b0);
      store(1'b0, 4'd2, 4'd2, d0);
      @(negedge clk);
      idle_in();
      @(negedge clk);
      expect_wr(8'd144, d1, 4'd4, 4'd4, 1'b1);
      store(1'b1, 4'd4, 4'd4, d1);
      @(negedge clk);
      store(1'b1, 4'd4, 4'd4, rand_data());
      @(negedge clk);
      idle_in();
      chk("ovf_pulse", err_ovf, 1);
      @(negedge clk);
      chk("ovf_pulse_len", err_ovf, 0);
      repeat (5) @(negedge clk);
      chk("ovf_writes", n_wr - w0, 2);
      query_m = 4; query_n = 4;
      @(negedge clk);
      chk("ovf_q44", query_cnt, 1);

      // clr while the third class-0 store is in LOOKUP.
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      run_vec('{1'b0, 4'd1, 4'd1, 4'd8, 8'd0, 4'd1, 1'b0}, 20);
      run_vec('{1'b0, 4'd1, 4'd1, 4'd8, 8'd1, 4'd2, 1'b0}, 21);
      w0 = n_wr;
      store(1'b0, 4'd1, 4'd1, rand_data());
      @(negedge clk);
      idle_in();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clrlk_wr_en", wr_en, 0);
      chk("clrlk_in_ack", in_ack, 0);
      query_m = 1; query_n = 1;
      @(negedge clk);
      chk("clrlk_q11", query_cnt, 0);
      query_m = 3; query_n = 3;
      @(negedge clk);
      chk("clrlk_q33", query_cnt, 0);
      chk("clrlk_no_wr", n_wr - w0, 0);
      run_vec('{1'b0, 4'd1, 4'd1, 4'd8, 8'd0, 4'd1, 1'b0}, 22);

      // clr beats a same-cycle store pulse.
      w0 = n_wr;
      clr = 1'b1;
      store(1'b1, 4'd2, 4'd2, rand_data());
      @(negedge clk);
      idle_in();
      chk("clrst_busy", busy, 0);
      chk("clrst_ovf", err_ovf, 0);
      repeat (4) @(negedge clk);
      chk("clrst_no_wr", n_wr - w0, 0);

      // Async reset during WRITE.
      d0 = rand_data();
      expect_wr(8'd48, d0, 4'd2, 4'd2, 1'b1);
      store(1'b1, 4'd2, 4'd2, d0);
      @(negedge clk);
      idle_in();
      @(negedge clk);
      @(negedge clk);
      chk("arst_pre_wr", wr_en, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wr_en", wr_en, 0);
      chk("arst_gen_ack", gen_ack, 0);
      chk("arst_wr_addr", wr_addr, 0);
      chk("arst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_after_wr", wr_en, 0);
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
